// File: rtl/fifo_rd_burst_if.sv
// ---------------------------------------------------------------------------
// fifo_rd_burst_if
//   Signal bundle for the read-side burst controller. It groups the burst
//   control (start/burst_len/busy/done/rd_count), the FIFO read port
//   (rempty/rdata/rinc) and the downstream valid/ready stream
//   (m_valid/m_data/m_ready).
//   slave  : the burst controller's view.
//   master : the environment's view (FIFO, requester and downstream sink).
// ---------------------------------------------------------------------------
interface fifo_rd_burst_if #(
  parameter int DSIZE = 8,
  parameter int LW    = 8
);
  // Burst control
  logic             start;
  logic [LW-1:0]    burst_len;
  logic             busy;
  logic             done;
  logic [LW-1:0]    rd_count;
  // FIFO read port
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  // Downstream stream
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_ready;

  modport slave (
    input  start, burst_len, rempty, rdata, m_ready,
    output rinc, m_valid, m_data, busy, done, rd_count
  );

  modport master (
    output start, burst_len, rempty, rdata, m_ready,
    input  rinc, m_valid, m_data, busy, done, rd_count
  );
endinterface

// File: rtl/fifo_rd_burst.sv
// ---------------------------------------------------------------------------
// fifo_rd_burst
//   Read-clock-domain burst controller for the async FIFO. A start request
//   pops burst_len words from the FIFO read port and streams them downstream
//   through a 2-entry output buffer; done pulses once the last word has been
//   accepted downstream.
//
// Ports
//   rclk    : read-domain clock (same as the FIFO read side)
//   rrst_n  : asynchronous active-low reset
//   bus     : fifo_rd_burst_if.slave
//             start/burst_len in, busy/done/rd_count out
//             rempty/rdata in, rinc out (combinational pop strobe)
//             m_ready in, m_valid/m_data out
// ---------------------------------------------------------------------------
module fifo_rd_burst #(
  parameter int DSIZE = 8,
  parameter int LW    = 8
) (
  input  logic           rclk,
  input  logic           rrst_n,
  fifo_rd_burst_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q,     state_d;
  logic [LW-1:0]    remaining_q, remaining_d;
  logic [LW-1:0]    rd_count_q,  rd_count_d;
  logic [1:0]       buf_cnt_q,   buf_cnt_d;
  logic [DSIZE-1:0] head_q,      head_d;
  logic [DSIZE-1:0] tail_q,      tail_d;

  logic push;  // FIFO pop == buffer push
  logic pop;   // downstream accept == buffer pop

  // The pop strobe deliberately ignores m_ready: room in the buffer is the
  // only flow-control term, so there is no combinational path from the
  // downstream sink to the FIFO read port.
  assign push = (state_q == BURST) && !bus.rempty &&
                (remaining_q != '0) && (buf_cnt_q < 2'd2);
  assign pop  = (buf_cnt_q != 2'd0) && bus.m_ready;

  assign bus.rinc     = push;
  assign bus.m_valid  = (buf_cnt_q != 2'd0);
  assign bus.m_data   = head_q;
  assign bus.busy     = (state_q == BURST) || (state_q == FLUSH);
  assign bus.done     = (state_q == DONE);
  assign bus.rd_count = rd_count_q;

  // Output buffer: head is always the word on m_data, tail the second entry.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    head_d    = head_q;
    tail_d    = tail_q;
    buf_cnt_d = buf_cnt_q;
    case ({push, pop})
      2'b10: begin
        if (buf_cnt_q == 2'd0) head_d = bus.rdata;
        else                   tail_d = bus.rdata;
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        head_d    = tail_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      // Push and pop together only happen with exactly one word buffered
      // (push needs a free slot, pop needs a word), so the new word simply
      // replaces the departing head.
      2'b11:   head_d = bus.rdata;
      default: ;
    endcase
  end

  // Burst sequencing
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    rd_count_d  = rd_count_q;

    if (push) begin
      remaining_d = remaining_q - LW'(1);
      rd_count_d  = rd_count_q + LW'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          remaining_d = bus.burst_len;
          rd_count_d  = '0;
          state_d     = (bus.burst_len != '0) ? BURST : DONE;
        end
      end
      BURST: begin
        // Decide on post-edge values so the last accept and the last pop
        // landing on the same edge go straight to DONE.
        if (remaining_d == '0)
          state_d = (buf_cnt_d == 2'd0) ? DONE : FLUSH;
      end
      FLUSH: begin
        if (buf_cnt_d == 2'd0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      rd_count_q  <= '0;
      buf_cnt_q   <= 2'd0;
      // NOTE: the two buffer entries are reset (unlike a RAM) so m_data
      // reads 0 out of reset and any words held mid-burst are discarded.
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      rd_count_q  <= rd_count_d;
      buf_cnt_q   <= buf_cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

endmodule

// File: doc/fifo_rd_burst.md
# fifo_rd_burst

Read-side burst controller for the async FIFO, living entirely in the read clock domain. On a start request it pops a programmed number of words from the FIFO read port (`rempty`/`rinc`/`rdata`) and presents them downstream on a valid/ready stream through a 2-entry output buffer. The FIFO's `rdata` is treated as combinational from the current read address, valid whenever `rempty` is low. The block pulses `done` once the burst has been fully delivered downstream.

## Interface
- `DSIZE`, 8, data word width; must match the FIFO's `DSIZE`.
- `LW`, 8, width of the burst length and word counter.
- `rclk`  in  1  read-domain clock, the same clock as the FIFO read side.
- `rrst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  burst request; sampled only in IDLE.
- `burst_len`  in  LW  number of words to read; sampled with `start`.
- `rempty`  in  1  FIFO empty flag.
- `rdata`  in  DSIZE  FIFO read data at the current read pointer.
- `rinc`  out  1  FIFO pop strobe (combinational).
- `m_valid`  out  1  output word valid.
- `m_data`  out  DSIZE  output word, the head of the output buffer.
- `m_ready`  in  1  downstream accept.
- `busy`  out  1  high in BURST and FLUSH.
- `done`  out  1  one-cycle pulse at burst completion.
- `rd_count`  out  LW  words popped from the FIFO in the current burst.

## Operation
- States:
  - IDLE: waits for `start`.
    - `start`=1 with `burst_len`≠0 → BURST; loads `remaining`=`burst_len` and clears `rd_count`.
    - `start`=1 with `burst_len`=0 → DONE; no pops occur.
  - BURST: pops words from the FIFO.
    - `remaining` reaches 0 with the buffer non-empty → FLUSH.
    - `remaining` reaches 0 with the buffer empty after this edge → DONE.
  - FLUSH: no pops. Goes to DONE once the buffer is empty after this edge.
  - DONE: `done`=1 for one cycle, then → IDLE.
- `start` outside IDLE is ignored, and so is `burst_len`.
- Pop rule:
  - `rinc` = (state==BURST) & !`rempty` & (`remaining`≠0) & (`buf_cnt`<2).
  - `rinc` has no dependency on `m_ready`; the FIFO read port therefore has no combinational path from the downstream side.
- Pop effects: on a `rinc` edge, `rdata` is written into the buffer tail, `remaining` decrements, and `rd_count` increments.
- Output buffer: a 2-entry FIFO.
  - `m_valid` = (`buf_cnt`≠0).
  - A word leaves when `m_valid` & `m_ready`.
  - A push and a pop in the same cycle leave `buf_cnt` unchanged and preserve ordering.
- `m_data` holds its value while `m_valid`=1 and `m_ready`=0.
- `busy` = state ∈ {BURST, FLUSH}.
- `rd_count` holds its final value after the burst until the next accepted `start`.

## Timing
- Reset (async assert, sync release) sets:
  - state=IDLE, `buf_cnt`=0, `remaining`=0, `rd_count`=0.
  - Outputs `rinc`=0, `m_valid`=0, `busy`=0, `done`=0. `m_data` reads as 0.
- Reset mid-burst drops buffered words and deasserts `rinc` immediately. The FIFO read side shares `rrst_n`.
- Latency:
  - `start` edge → BURST on the next cycle.
  - The first `rinc` can occur in that cycle, provided the FIFO is non-empty.
  - `m_valid` rises the cycle after the pop edge.
  - Total: `start` → first `m_valid` = 2 cycles minimum.
- Throughput: with `m_ready` held at 1, the block sustains one word per cycle (`buf_cnt` stays at 1).
- Backpressure:
  - With `m_ready`=0, at most 2 words are popped, then `rinc` stays low.
  - Popping resumes the cycle after the first accept.
- `rempty` high in BURST:
  - The block stalls with no timeout and stays in BURST.
  - The `rempty` synchronizer lag is tolerated; no pop is issued while `rempty`=1.
- Completion:
  - `done` is asserted in the cycle after the final downstream accept.
  - Exception: for `burst_len`=0, `done` is asserted the cycle after `start`.
- Width: `burst_len` covers up to 2^LW−1 words. `rd_count` never wraps within a burst.

## Test plan
- Reset, write 16 words 1..16 into the FIFO, `start` with `burst_len`=16 and `m_ready`=1 → `m_data` sequence 1..16, one word per cycle once the FIFO is non-empty; `rd_count`=16; a single `done` pulse; `rempty`=1 at the end.
- 8 words in the FIFO, `burst_len`=4 → exactly 4 pops (data 1..4), `done`, and 4 words left in the FIFO. A second `start` with `burst_len`=4 → data 5..8.
- `m_ready`=0 for 10 cycles during a 6-word burst → only 2 pops, `m_data`=1 held stable. Then `m_ready`=1 → 1..6 in order with no loss or duplication.
- `burst_len`=5 with only 3 words written → block stalls in BURST with `busy`=1 after 3 words. Write words 4 and 5 later → delivery completes and `done` pulses.
- `burst_len`=0 → `done` the cycle after `start`, `rinc` never high. `start` pulsed mid-burst → ignored, `rd_count` unaffected.
- Assert `rrst_n` after 3 of 10 words have been delivered → `m_valid`, `busy`, and `rinc` drop asynchronously and `rd_count`=0. After release, the block sits in IDLE and accepts a new `start`.
